ccu_nibble_loader: RTL and testbench

- Upstream input stage for the ccu cipher core.
- Collects NIBBLES data/key nibble pairs from the pin interface under a valid/ready handshake into an internal block buffer.
- Replays the buffered pairs in order to the ccu, one pair per accepted beat, with a last flag.
- Lets the external host load a full block at its own pace while the ccu sees a clean, gap-controlled stream.

---
 rtl/ccu_nibble_loader_if.sv | 23 ++
 rtl/ccu_nibble_loader.sv | 100 ++++++++++
 tb/tb_ccu_nibble_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ccu_nibble_loader_if.sv
// Host-side and ccu-side handshake bundle for the nibble loader.
// The master modport is the environment view; the slave modport is the loader.
interface ccu_nibble_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] din;
  logic [3:0] kin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic [3:0] key_out;
  logic       out_last;

  modport master (
    output in_valid, din, kin, out_ready,
    input  in_ready, out_valid, data_out, key_out, out_last
  );

  modport slave (
    input  in_valid, din, kin, out_ready,
    output in_ready, out_valid, data_out, key_out, out_last
  );
endinterface

// File: rtl/ccu_nibble_loader.sv
// Buffers one block of data/key nibble pairs from the host, then replays
// it in order to the ccu core with a last flag. Fill and drain never overlap.
module ccu_nibble_loader #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  output logic                busy,
  ccu_nibble_loader_if.slave  bus
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wr_cnt, wr_cnt_nxt;
  logic [CW-1:0]   rd_cnt, rd_cnt_nxt;
  logic [7:0]      buf_q [NIBBLES];
  logic            wr_en;
  logic            rd_last;
  logic            fill_st;
  logic            drain_st;

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    wr_en      = 1'b0;
    rd_last    = (rd_cnt == LAST);
    if (clear) begin
      // Abort wins over any coinciding handshake: nothing is written.
      state_nxt  = FILL;
      wr_cnt_nxt = '0;
      rd_cnt_nxt = '0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            wr_en = 1'b1;
            if (wr_cnt == LAST) begin
              state_nxt  = DRAIN;
              wr_cnt_nxt = '0;
              rd_cnt_nxt = '0;
            end else begin
              wr_cnt_nxt = wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_last) begin
              state_nxt  = FILL;
              rd_cnt_nxt = '0;
            end else begin
              rd_cnt_nxt = rd_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
      for (int i = 0; i < NIBBLES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
      rd_cnt <= rd_cnt_nxt;
      if (wr_en) begin
        buf_q[wr_cnt] <= {bus.din, bus.kin};
      end
    end
  end

  // Handshake outputs are forced low while reset is held, even before the
  // first sampling edge has returned the state register to FILL.
  assign fill_st  = rst_n && (state == FILL);
  assign drain_st = rst_n && (state == DRAIN);

  assign bus.in_ready  = fill_st;
  assign bus.out_valid = drain_st;
  assign busy          = drain_st;
  assign bus.data_out  = drain_st ? buf_q[rd_cnt][7:4] : 4'h0;
  assign bus.key_out   = drain_st ? buf_q[rd_cnt][3:0] : 4'h0;
  assign bus.out_last  = drain_st ? rd_last : 1'b0;

endmodule

// File: tb/tb_ccu_nibble_loader.sv
// Directed bench for ccu_nibble_loader: a vector table for the main flows,
// followed by hand-written backpressure and reset-mid-drain sequences.
module tb_ccu_nibble_loader;

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;

  ccu_nibble_loader_if bus_if ();

  ccu_nibble_loader #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .busy  (busy),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {in_ready, out_valid, data, key, last, busy}.
  typedef struct {
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [3:0]  din;
    logic [3:0]  kin;
    logic        out_ready;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [11:0] pk(logic ir, logic ov, logic [3:0] d,
                                     logic [3:0] k, logic l);
    return {ir, ov, d, k, l, ov};
  endfunction

  function automatic void addVec(logic r, logic c, logic iv, logic [3:0] d,
                                 logic [3:0] k, logic ordy, logic [11:0] e);
    vec_t v;
    v.rst_n = r; v.clear = c; v.in_valid = iv;
    v.din = d; v.kin = k; v.out_ready = ordy; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void addFill(logic [3:0] d, logic [3:0] k);
    addVec(1'b1, 1'b0, 1'b1, d, k, 1'b0, pk(1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
  endfunction

  function automatic void addGap();
    addVec(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, pk(1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
  endfunction

  function automatic void addDrain(logic [3:0] d, logic [3:0] k, logic l);
    addVec(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, pk(1'b0, 1'b1, d, k, l));
  endfunction

  task automatic applyStimulus(logic r, logic c, logic iv, logic [3:0] d,
                               logic [3:0] k, logic ordy);
    @(negedge clk);
    rst_n            = r;
    clear            = c;
    bus_if.in_valid  = iv;
    bus_if.din       = d;
    bus_if.kin       = k;
    bus_if.out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(string name, int idx, logic [11:0] exp);
    logic [11:0] act;
    act = {bus_if.in_ready, bus_if.out_valid, bus_if.data_out,
           bus_if.key_out, bus_if.out_last, busy};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s%0d: got ir=%b ov=%b d=%h k=%h last=%b busy=%b, want ir=%b ov=%b d=%h k=%h last=%b busy=%b",
               name, idx, act[11], act[10], act[9:6], act[5:2], act[1], act[0],
               exp[11], exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(int idx, logic r, logic c, logic iv, logic [3:0] d,
                      logic [3:0] k, logic ordy, logic [11:0] exp);
    applyStimulus(r, c, iv, d, k, ordy);
    checkOutput("seq", idx, exp);
  endtask

  initial begin
    rst_n            = 1'b0;
    clear            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.din       = 4'h0;
    bus_if.kin       = 4'h0;
    bus_if.out_ready = 1'b0;

    // Reset held two cycles, then a back-to-back fill and full-speed drain.
    addVec(1'b0, 1'b0, 1'b1, 4'h7, 4'h7, 1'b1, pk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    addVec(1'b0, 1'b0, 1'b1, 4'h7, 4'h7, 1'b1, pk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    addFill(4'h1, 4'hA); addFill(4'h2, 4'hB); addFill(4'h3, 4'hC); addFill(4'h4, 4'hD);
    addDrain(4'h1, 4'hA, 1'b0); addDrain(4'h2, 4'hB, 1'b0);
    addDrain(4'h3, 4'hC, 1'b0); addDrain(4'h4, 4'hD, 1'b1);
    addGap();
    // Sparse input: in_valid 1,0,0,1,0,1,1.
    addFill(4'h5, 4'h0); addGap(); addGap(); addFill(4'h6, 4'h1);
    addGap(); addFill(4'h7, 4'h2); addFill(4'h8, 4'h3);
    addDrain(4'h5, 4'h0, 1'b0); addDrain(4'h6, 4'h1, 1'b0);
    addDrain(4'h7, 4'h2, 1'b0); addDrain(4'h8, 4'h3, 1'b1);
    // Clear alongside a third pair drops it and restarts at slot 0.
    addFill(4'h9, 4'hE); addFill(4'h8, 4'hF);
    addVec(1'b1, 1'b1, 1'b1, 4'h7, 4'h7, 1'b0, pk(1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    addFill(4'h1, 4'h1); addFill(4'h2, 4'h2); addFill(4'h3, 4'h3); addFill(4'h4, 4'h4);
    addDrain(4'h1, 4'h1, 1'b0); addDrain(4'h2, 4'h2, 1'b0);
    addDrain(4'h3, 4'h3, 1'b0); addDrain(4'h4, 4'h4, 1'b1);
    addGap();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].clear, vecs[i].in_valid,
                    vecs[i].din, vecs[i].kin, vecs[i].out_ready);
      checkOutput("vec", i, vecs[i].exp);
    end

    // Backpressure at pair 2/B for three cycles; host pushes during drain.
    step(0, 1, 0, 1, 4'h1, 4'hA, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(1, 1, 0, 1, 4'h2, 4'hB, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(2, 1, 0, 1, 4'h3, 4'hC, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(3, 1, 0, 1, 4'h4, 4'hD, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(4, 1, 0, 1, 4'hE, 4'hE, 1, pk(0, 1, 4'h1, 4'hA, 0));
    step(5, 1, 0, 1, 4'hE, 4'hE, 0, pk(0, 1, 4'h2, 4'hB, 0));
    step(6, 1, 0, 0, 4'h0, 4'h0, 0, pk(0, 1, 4'h2, 4'hB, 0));
    step(7, 1, 0, 0, 4'h0, 4'h0, 0, pk(0, 1, 4'h2, 4'hB, 0));
    step(8, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h2, 4'hB, 0));
    step(9, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h3, 4'hC, 0));
    step(10, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h4, 4'hD, 1));
    step(11, 1, 0, 0, 4'h0, 4'h0, 1, pk(1, 0, 4'h0, 4'h0, 0));

    // Reset while rd_cnt==2, then confirm nothing stale is replayed.
    step(20, 1, 0, 1, 4'h9, 4'h1, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(21, 1, 0, 1, 4'hA, 4'h2, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(22, 1, 0, 1, 4'hB, 4'h3, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(23, 1, 0, 1, 4'hC, 4'h4, 0, pk(1, 0, 4'h0, 4'h0, 0));
    step(24, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h9, 4'h1, 0));
    step(25, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'hA, 4'h2, 0));
    step(26, 0, 0, 0, 4'h0, 4'h0, 1, pk(0, 0, 4'h0, 4'h0, 0));
    step(27, 1, 0, 0, 4'h0, 4'h0, 1, pk(1, 0, 4'h0, 4'h0, 0));
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.buf_q[i] !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL buf_zero%0d: got %h, want 00", i, dut.buf_q[i]);
      end
    end
    step(28, 1, 0, 0, 4'h0, 4'h0, 1, pk(1, 0, 4'h0, 4'h0, 0));
    step(29, 1, 0, 1, 4'h6, 4'h9, 1, pk(1, 0, 4'h0, 4'h0, 0));
    step(30, 1, 0, 1, 4'h7, 4'h8, 1, pk(1, 0, 4'h0, 4'h0, 0));
    step(31, 1, 0, 1, 4'h8, 4'h7, 1, pk(1, 0, 4'h0, 4'h0, 0));
    step(32, 1, 0, 1, 4'h9, 4'h6, 1, pk(1, 0, 4'h0, 4'h0, 0));
    step(33, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h6, 4'h9, 0));
    step(34, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h7, 4'h8, 0));
    step(35, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h8, 4'h7, 0));
    step(36, 1, 0, 0, 4'h0, 4'h0, 1, pk(0, 1, 4'h9, 4'h6, 1));
    step(37, 1, 0, 0, 4'h0, 4'h0, 1, pk(1, 0, 4'h0, 4'h0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
